// File: rtl/keypad_scanner.sv
// keypad_scanner: one-hot column scan, single-key debounce and a one-deep key event buffer.
// Defining KEYPAD_GHOST_REJECT_EN treats multi-row samples as no key during scanning.
module keypad_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    localparam int CW             = $clog2(ROWS * COLS)
) (
    input  logic            slow_clk,
    input  logic            rst,
    input  logic [ROWS-1:0] row_in,
    output logic [COLS-1:0] col_drive,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            key_pressed,
    output logic            overrun
);

    localparam int CIW = $clog2(COLS);
    localparam int RIW = $clog2(ROWS);
    localparam int DW  = $clog2(SETTLE_CYCLES + 1);
    localparam int BW  = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CIW-1:0]  r_col_idx;
    logic [COLS-1:0] r_col_drive;
    logic [DW-1:0]   r_dwell;
    logic [BW-1:0]   r_cnt;
    logic [ROWS-1:0] r_pattern;
    logic [RIW-1:0]  r_row_idx;
    logic [CW-1:0]   r_key_code;
    logic            r_key_valid;
    logic            r_key_pressed;
    logic            r_overrun;

    logic w_sample_last;
    logic w_deb_done;
    logic w_row_hit;
    logic w_row_zero;
    logic w_row_match;
    logic w_capture;
    logic w_issue;
    logic w_release_done;
    logic w_advance;
    logic w_accept;
    logic w_cnt_inc;

    function automatic logic [RIW-1:0] f_lowest_row(input logic [ROWS-1:0] v);
        logic [RIW-1:0] idx;
        idx = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (v[r]) idx = RIW'(r);
        end
        return idx;
    endfunction

`ifdef KEYPAD_GHOST_REJECT_EN
    localparam logic [ROWS-1:0] ROW_ONE = ROWS'(1);

    function automatic logic f_multi_bit(input logic [ROWS-1:0] v);
        return (v & (v - ROW_ONE)) != '0;
    endfunction

    assign w_row_hit = (row_in != '0) && !f_multi_bit(row_in);
`else
    assign w_row_hit = (row_in != '0);
`endif

    assign w_sample_last = (r_dwell == DW'(SETTLE_CYCLES - 1));
    assign w_deb_done    = (r_cnt == BW'(DEBOUNCE_CYCLES - 1));
    assign w_row_zero    = (row_in == '0);
    assign w_row_match   = (row_in == r_pattern);

    // State register.
    always_ff @(posedge slow_clk) begin
        if (!rst) r_state <= ST_SCAN;
        else      r_state <= w_state_nxt;
    end

    // Next-state decision.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SCAN:     if (w_sample_last && w_row_hit) w_state_nxt = ST_DEBOUNCE;
                         else                            w_state_nxt = ST_SCAN;
            ST_DEBOUNCE: if (!w_row_match)               w_state_nxt = ST_SCAN;
                         else if (w_deb_done)            w_state_nxt = ST_HELD;
                         else                            w_state_nxt = ST_DEBOUNCE;
            ST_HELD:     if (w_row_zero)                 w_state_nxt = ST_RELEASE;
                         else                            w_state_nxt = ST_HELD;
            ST_RELEASE:  if (!w_row_zero)                w_state_nxt = ST_HELD;
                         else if (w_deb_done)            w_state_nxt = ST_SCAN;
                         else                            w_state_nxt = ST_RELEASE;
            default:                                     w_state_nxt = ST_SCAN;
        endcase
    end

    // Per-state strobes that steer the registered datapath.
    always_comb begin
        w_capture      = 1'b0;
        w_issue        = 1'b0;
        w_release_done = 1'b0;
        w_cnt_inc      = 1'b0;
        case (r_state)
            ST_SCAN:     w_capture = w_sample_last && w_row_hit;
            ST_DEBOUNCE: begin
                w_issue   = w_row_match && w_deb_done;
                w_cnt_inc = w_row_match && !w_deb_done;
            end
            ST_HELD:     w_cnt_inc = 1'b0;
            ST_RELEASE:  begin
                w_release_done = w_row_zero && w_deb_done;
                w_cnt_inc      = w_row_zero && !w_deb_done;
            end
            default:     w_capture = 1'b0;
        endcase
        w_advance = ((r_state == ST_SCAN) && w_sample_last && !w_row_hit) || w_release_done;
        w_accept  = r_key_valid && key_ready;
    end

    // Scan counters, captured pattern and registered outputs.
    always_ff @(posedge slow_clk) begin
        if (!rst) begin
            r_col_idx     <= '0;
            r_col_drive   <= COLS'(1);
            r_dwell       <= '0;
            r_cnt         <= '0;
            r_pattern     <= '0;
            r_row_idx     <= '0;
            r_key_code    <= '0;
            r_key_valid   <= 1'b0;
            r_key_pressed <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_overrun <= 1'b0;

            if ((r_state == ST_SCAN) && !w_sample_last) r_dwell <= r_dwell + DW'(1);
            else                                        r_dwell <= '0;

            if (w_cnt_inc) r_cnt <= r_cnt + BW'(1);
            else           r_cnt <= '0;

            if (w_advance) begin
                r_col_idx   <= (r_col_idx == CIW'(COLS - 1)) ? '0 : r_col_idx + CIW'(1);
                r_col_drive <= {r_col_drive[COLS-2:0], r_col_drive[COLS-1]};
            end else begin
                r_col_idx   <= r_col_idx;
                r_col_drive <= r_col_drive;
            end

            if (w_capture) begin
                r_pattern <= row_in;
                r_row_idx <= f_lowest_row(row_in);
            end else begin
                r_pattern <= r_pattern;
                r_row_idx <= r_row_idx;
            end

            // An accept in the issue cycle frees the buffer before the new event lands.
            if (w_issue && (!r_key_valid || w_accept)) begin
                r_key_code  <= CW'(int'(r_row_idx) * COLS + int'(r_col_idx));
                r_key_valid <= 1'b1;
            end else if (w_issue) begin
                r_overrun   <= 1'b1;
            end else if (w_accept) begin
                r_key_valid <= 1'b0;
            end else begin
                r_key_valid <= r_key_valid;
            end

            if (w_issue)             r_key_pressed <= 1'b1;
            else if (w_release_done) r_key_pressed <= 1'b0;
            else                     r_key_pressed <= r_key_pressed;
        end
    end

    assign col_drive   = r_col_drive;
    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_pressed = r_key_pressed;
    assign overrun     = r_overrun;

endmodule
